// File: rtl/ysyx_2022040010_mem_arbiter.sv
// Memory arbiter: grants one of NPORT requesters, issues a single downstream
// transaction, and returns a one-cycle completion pulse to the granted port.
module ysyx_2022040010_mem_arbiter #(
  parameter int unsigned NPORT   = 3,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned RR_EN   = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORT-1:0]           req_valid_i,
  input  logic [NPORT-1:0]           req_we_i,
  input  logic [NPORT*ADDR_W-1:0]    req_addr_i,
  input  logic [NPORT*DATA_W-1:0]    req_wdata_i,
  input  logic [NPORT*DATA_W/8-1:0]  req_mask_i,
  input  logic [NPORT*2-1:0]         req_size_i,
  output logic [NPORT-1:0]           req_ready_o,
  output logic [DATA_W-1:0]          resp_data_o,
  output logic                       resp_err_o,
  output logic                       rw_valid_o,
  input  logic                       rw_ready_i,
  output logic                       rw_req_o,
  output logic [ADDR_W-1:0]          rw_addr_o,
  output logic [DATA_W-1:0]          data_write_o,
  output logic [1:0]                 rw_size_o,
  output logic [DATA_W/8-1:0]        w_mask_o,
  output logic [ID_W-1:0]            rw_id_o,
  input  logic [ID_W-1:0]            rw_id_i,
  input  logic [DATA_W-1:0]          data_read_i,
  output logic                       stallreq_o,
  output logic                       id_err_o
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned PTR_W  = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rw_valid_q, rw_valid_d;
  logic               rw_req_q, rw_req_d;
  logic [ADDR_W-1:0]  rw_addr_q, rw_addr_d;
  logic [DATA_W-1:0]  data_write_q, data_write_d;
  logic [1:0]         rw_size_q, rw_size_d;
  logic [MASK_W-1:0]  w_mask_q, w_mask_d;
  logic [ID_W-1:0]    rw_id_q, rw_id_d;
  logic [NPORT-1:0]   req_ready_q, req_ready_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic               resp_err_q, resp_err_d;
  logic               id_err_q, id_err_d;

  logic               gnt_vld_c;
  logic [PTR_W-1:0]   gnt_idx_c;
  logic               sel_we_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic [DATA_W-1:0]  sel_wdata_c;
  logic [MASK_W-1:0]  sel_mask_c;
  logic [1:0]         sel_size_c;

  // Pick the winning port: rotating start after the last grant, or lowest index.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      int unsigned cand;
      cand = (RR_EN != 0) ? ((32'(ptr_q) + 32'd1 + i) % NPORT) : i;
      if (!gnt_vld_c && req_valid_i[PTR_W'(cand)]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = PTR_W'(cand);
      end
    end
  end

  // Mux the winning port's request fields.
  always_comb begin
    sel_we_c    = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    sel_mask_c  = '0;
    sel_size_c  = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (gnt_idx_c == PTR_W'(p)) begin
        sel_we_c    = req_we_i[p];
        sel_addr_c  = req_addr_i[p*ADDR_W +: ADDR_W];
        sel_wdata_c = req_wdata_i[p*DATA_W +: DATA_W];
        sel_mask_c  = req_mask_i[p*MASK_W +: MASK_W];
        sel_size_c  = req_size_i[p*2 +: 2];
      end
    end
  end

  // Next-state and registered-output logic; response fields default to zero.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    rw_valid_d   = rw_valid_q;
    rw_req_d     = rw_req_q;
    rw_addr_d    = rw_addr_q;
    data_write_d = data_write_q;
    rw_size_d    = rw_size_q;
    w_mask_d     = w_mask_q;
    rw_id_d      = rw_id_q;
    req_ready_d  = '0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;
    id_err_d     = id_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_vld_c) begin
          state_d      = ST_WAIT;
          gnt_d        = gnt_idx_c;
          if (RR_EN != 0) ptr_d = gnt_idx_c;
          cnt_d        = '0;
          rw_valid_d   = 1'b1;
          rw_req_d     = sel_we_c;
          rw_addr_d    = sel_addr_c;
          data_write_d = sel_wdata_c;
          rw_size_d    = sel_size_c;
          w_mask_d     = sel_mask_c;
          rw_id_d      = ID_W'(gnt_idx_c);
        end
      end
      ST_WAIT: begin
        if (rw_ready_i && (rw_id_i == ID_W'(gnt_q))) begin
          state_d     = ST_RESP;
          req_ready_d = NPORT'(1) << gnt_q;
          resp_data_d = data_read_i;
        end else begin
          if (rw_ready_i) id_err_d = 1'b1;
          if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
            state_d     = ST_RESP;
            req_ready_d = NPORT'(1) << gnt_q;
            resp_err_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Downstream outputs return to zero as soon as WAIT ends.
        if (state_d == ST_RESP) begin
          rw_valid_d   = 1'b0;
          rw_req_d     = 1'b0;
          rw_addr_d    = '0;
          data_write_d = '0;
          rw_size_d    = '0;
          w_mask_d     = '0;
          rw_id_d      = '0;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= PTR_W'(NPORT - 1);
      gnt_q        <= '0;
      cnt_q        <= '0;
      rw_valid_q   <= 1'b0;
      rw_req_q     <= 1'b0;
      rw_addr_q    <= '0;
      data_write_q <= '0;
      rw_size_q    <= '0;
      w_mask_q     <= '0;
      rw_id_q      <= '0;
      req_ready_q  <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      id_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      rw_valid_q   <= rw_valid_d;
      rw_req_q     <= rw_req_d;
      rw_addr_q    <= rw_addr_d;
      data_write_q <= data_write_d;
      rw_size_q    <= rw_size_d;
      w_mask_q     <= w_mask_d;
      rw_id_q      <= rw_id_d;
      req_ready_q  <= req_ready_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      id_err_q     <= id_err_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign rw_valid_o   = rw_valid_q;
  assign rw_req_o     = rw_req_q;
  assign rw_addr_o    = rw_addr_q;
  assign data_write_o = data_write_q;
  assign rw_size_o    = rw_size_q;
  assign w_mask_o     = w_mask_q;
  assign rw_id_o      = rw_id_q;
  assign id_err_o     = id_err_q;

  // Stall while any requester is still waiting for its completion pulse.
  assign stallreq_o = |(req_valid_i & ~req_ready_o);

endmodule

// File: tb/tb_ysyx_2022040010_mem_arbiter.sv
// Bench for the memory arbiter: vector table, directed corner sequences and
// a randomized run checked against a transaction-level model.
module tb_ysyx_2022040010_mem_arbiter;

  localparam int unsigned NP = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 8;
  localparam int unsigned IW = 4;
  localparam int unsigned TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req_valid, req_we;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata;
  logic [NP*MW-1:0]  req_mask;
  logic [NP*2-1:0]   req_size;
  logic              rw_ready, rw_ready_f;
  logic [IW-1:0]     rw_id, rw_id_f;
  logic [DW-1:0]     data_read;

  logic [NP-1:0]     req_ready, req_ready_f;
  logic [DW-1:0]     resp_data, resp_data_f;
  logic              resp_err, resp_err_f;
  logic              rw_valid, rw_valid_f;
  logic              rw_req, rw_req_f;
  logic [AW-1:0]     rw_addr, rw_addr_f;
  logic [DW-1:0]     data_write, data_write_f;
  logic [1:0]        rw_size, rw_size_f;
  logic [MW-1:0]     w_mask, w_mask_f;
  logic [IW-1:0]     rw_id_o, rw_id_o_f;
  logic              stallreq, stallreq_f;
  logic              id_err, id_err_f;

  int checks = 0;
  int errors = 0;

  ysyx_2022040010_mem_arbiter #(.NPORT(NP), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW),
                                .RR_EN(1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_mask_i(req_mask),
    .req_size_i(req_size), .req_ready_o(req_ready), .resp_data_o(resp_data),
    .resp_err_o(resp_err), .rw_valid_o(rw_valid), .rw_ready_i(rw_ready),
    .rw_req_o(rw_req), .rw_addr_o(rw_addr), .data_write_o(data_write),
    .rw_size_o(rw_size), .w_mask_o(w_mask), .rw_id_o(rw_id_o), .rw_id_i(rw_id),
    .data_read_i(data_read), .stallreq_o(stallreq), .id_err_o(id_err)
  );

  ysyx_2022040010_mem_arbiter #(.NPORT(NP), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW),
                                .RR_EN(0), .TIMEOUT(TO)) dut_fp (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_mask_i(req_mask),
    .req_size_i(req_size), .req_ready_o(req_ready_f), .resp_data_o(resp_data_f),
    .resp_err_o(resp_err_f), .rw_valid_o(rw_valid_f), .rw_ready_i(rw_ready_f),
    .rw_req_o(rw_req_f), .rw_addr_o(rw_addr_f), .data_write_o(data_write_f),
    .rw_size_o(rw_size_f), .w_mask_o(w_mask_f), .rw_id_o(rw_id_o_f), .rw_id_i(rw_id_f),
    .data_read_i(data_read), .stallreq_o(stallreq_f), .id_err_o(id_err_f)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    int          delay;
    logic [63:0] rdata;
    int          exp_gnt;
  } vec_t;

  vec_t vecs[8];

  // Model state for the randomized run.
  bit          m_busy, m_resp, m_rerr, m_iderr;
  int          m_port, m_last, m_issue;
  logic        m_we;
  logic [31:0] m_addr;
  logic [63:0] m_wdata, m_rdata;
  logic [7:0]  m_mask;
  logic [1:0]  m_size;
  int          gr[$];
  int          gf[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] p_addr(int p);
    return 32'h8000_0000 + 32'(p) * 32'h10;
  endfunction
  function automatic logic [63:0] p_wdata(int p);
    return 64'hC0DE_0000_0000_0000 | 64'(p);
  endfunction
  function automatic logic [7:0] p_mask(int p);
    return 8'(8'h0F << p);
  endfunction
  function automatic logic [1:0] p_size(int p);
    return 2'(p + 1);
  endfunction
  function automatic logic p_we(int p);
    return (p == 2);
  endfunction
  function automatic int oh2i(logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_fixed_fields();
    for (int p = 0; p < 3; p++) begin
      req_we[p]             = p_we(p);
      req_addr[p*AW +: AW]  = p_addr(p);
      req_wdata[p*DW +: DW] = p_wdata(p);
      req_mask[p*MW +: MW]  = p_mask(p);
      req_size[p*2 +: 2]    = p_size(p);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0; rw_ready = 1'b0; rw_ready_f = 1'b0;
    rw_id = '0; rw_id_f = '0; data_read = '0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  initial begin
    vecs[0] = '{3'b010, 4, 64'hDEAD_BEEF_0000_0001, 1};
    vecs[1] = '{3'b111, 2, 64'h0123_4567_89AB_CDEF, 2};
    vecs[2] = '{3'b111, 1, 64'hFFFF_0000_FFFF_0000, 0};
    vecs[3] = '{3'b101, 3, 64'h0000_0000_0000_0055, 2};
    vecs[4] = '{3'b011, 2, 64'hA5A5_A5A5_5A5A_5A5A, 0};
    vecs[5] = '{3'b110, 5, 64'h1111_2222_3333_4444, 1};
    vecs[6] = '{3'b001, 1, 64'h8000_0000_0000_0000, 0};
    vecs[7] = '{3'b100, 2, 64'h0000_0000_0000_0001, 2};

    set_fixed_fields();
    do_reset();

    // Reset state.
    #2;
    chk("rst_rw_valid", 64'(rw_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_id_err", 64'(id_err), 64'd0);
    chk("rst_rw_addr", 64'(rw_addr), 64'd0);

    // Single transactions from a vector table.
    for (int i = 0; i < 8; i++) begin
      req_valid = vecs[i].valid;
      #2;
      chk("vec_stall_idle", 64'(stallreq), 64'(vecs[i].valid != 3'b000));
      step();
      req_valid = '0;
      #2;
      chk("vec_rw_valid", 64'(rw_valid), 64'd1);
      chk("vec_rw_id", 64'(rw_id_o), 64'(vecs[i].exp_gnt));
      chk("vec_rw_addr", 64'(rw_addr), 64'(p_addr(vecs[i].exp_gnt)));
      chk("vec_rw_req", 64'(rw_req), 64'(p_we(vecs[i].exp_gnt)));
      chk("vec_rw_size", 64'(rw_size), 64'(p_size(vecs[i].exp_gnt)));
      chk("vec_w_mask", 64'(w_mask), 64'(p_mask(vecs[i].exp_gnt)));
      chk("vec_data_write", data_write, p_wdata(vecs[i].exp_gnt));
      for (int c = 2; c <= vecs[i].delay; c++) step();
      rw_ready = 1'b1;
      rw_id = IW'(vecs[i].exp_gnt);
      data_read = vecs[i].rdata;
      #2;
      chk("vec_wait_ready_low", 64'(req_ready), 64'd0);
      chk("vec_wait_addr", 64'(rw_addr), 64'(p_addr(vecs[i].exp_gnt)));
      step();
      rw_ready = 1'b0;
      data_read = '0;
      #2;
      chk("vec_req_ready", 64'(req_ready), 64'(3'b001 << vecs[i].exp_gnt));
      chk("vec_resp_data", resp_data, vecs[i].rdata);
      chk("vec_resp_err", 64'(resp_err), 64'd0);
      chk("vec_resp_rw_valid", 64'(rw_valid), 64'd0);
      chk("vec_resp_rw_addr", 64'(rw_addr), 64'd0);
      step();
      #2;
      chk("vec_idle_ready", 64'(req_ready), 64'd0);
      chk("vec_idle_data", resp_data, 64'd0);
    end

    // Mismatched completion ID while port 2 waits; late input changes ignored.
    req_valid = 3'b100;
    step();
    req_valid = '0;
    req_addr[2*AW +: AW] = 32'h1234_5678;
    #2;
    chk("mm_rw_id", 64'(rw_id_o), 64'd2);
    chk("mm_addr_held", 64'(rw_addr), 64'(p_addr(2)));
    step();
    rw_ready = 1'b1; rw_id = 4'd0; data_read = 64'h5555_6666_7777_8888;
    step();
    rw_ready = 1'b0;
    #2;
    chk("mm_still_wait", 64'(rw_valid), 64'd1);
    chk("mm_no_ready", 64'(req_ready), 64'd0);
    chk("mm_id_err", 64'(id_err), 64'd1);
    rw_ready = 1'b1; rw_id = 4'd2; data_read = 64'h0BAD_F00D_0000_0002;
    step();
    rw_ready = 1'b0;
    #2;
    chk("mm_ready", 64'(req_ready), 64'(3'b100));
    chk("mm_data", resp_data, 64'h0BAD_F00D_0000_0002);
    chk("mm_id_err_sticky", 64'(id_err), 64'd1);
    set_fixed_fields();
    step();

    // Timeout: request in cycle 0, no completion.
    req_valid = 3'b001;
    step();
    req_valid = '0;
    for (int c = 1; c <= 9; c++) begin
      #2;
      chk("to_no_ready", 64'(req_ready), 64'd0);
      chk("to_rw_valid", 64'(rw_valid), 64'd1);
      step();
    end
    #2;
    chk("to_ready", 64'(req_ready), 64'(3'b001));
    chk("to_err", 64'(resp_err), 64'd1);
    chk("to_data", resp_data, 64'd0);
    step();
    #2;
    chk("to_err_clear", 64'(resp_err), 64'd0);

    // Round-robin vs fixed priority with all ports held valid.
    do_reset();
    begin
      int ar, af;
      ar = 0; af = 0;
      gr.delete(); gf.delete();
      req_valid = 3'b111;
      for (int c = 0; c < 120 && (gr.size() < 4 || gf.size() < 4); c++) begin
        ar = rw_valid ? ar + 1 : 0;
        af = rw_valid_f ? af + 1 : 0;
        rw_ready = (ar == 3);
        rw_id = rw_id_o;
        rw_ready_f = (af == 3);
        rw_id_f = rw_id_o_f;
        data_read = 64'(c);
        #2;
        if (req_ready != '0) gr.push_back(oh2i(req_ready));
        if (req_ready_f != '0) gf.push_back(oh2i(req_ready_f));
        step();
      end
      req_valid = '0; rw_ready = 1'b0; rw_ready_f = 1'b0;
      chk("rr_count", 64'(gr.size()), 64'd4);
      chk("fp_count", 64'(gf.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
        if (i < gr.size()) chk("rr_order", 64'(gr[i]), 64'(i % 3));
        if (i < gf.size()) chk("fp_order", 64'(gf[i]), 64'd0);
      end
    end

    // Reset in the middle of WAIT.
    do_reset();
    req_valid = 3'b010;
    step();
    req_valid = '0;
    #2;
    chk("rmw_rw_valid", 64'(rw_valid), 64'd1);
    chk("rmw_rw_id", 64'(rw_id_o), 64'd1);
    rst = 1'b0;
    #1;
    chk("rmw_drop_now", 64'(rw_valid), 64'd0);
    rw_ready = 1'b1; rw_id = 4'd1;
    repeat (3) begin
      step();
      #2;
      chk("rmw_no_ready", 64'(req_ready), 64'd0);
    end
    rw_ready = 1'b0;
    rst = 1'b1;
    req_valid = 3'b111;
    step();
    #2;
    chk("rmw_first_grant_valid", 64'(rw_valid), 64'd1);
    chk("rmw_first_grant_id", 64'(rw_id_o), 64'd0);

    // Randomized run against a transaction-level model.
    do_reset();
    m_busy = 0; m_resp = 0; m_rerr = 0; m_iderr = 0;
    m_port = 0; m_last = 2; m_issue = 0; m_rdata = '0;
    m_we = 0; m_addr = '0; m_wdata = '0; m_mask = '0; m_size = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [2:0] exp_ready;
      int div;
      div = (cyc < 300) ? 3 : 12;
      req_valid = 3'($urandom);
      req_we    = 3'($urandom);
      req_addr  = {$urandom, $urandom, $urandom};
      req_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      req_mask  = 24'($urandom);
      req_size  = 6'($urandom);
      rw_ready  = ($urandom_range(0, div - 1) == 0);
      rw_id     = ($urandom_range(0, 4) == 0) ? IW'($urandom_range(0, 3)) : IW'(m_port);
      data_read = {$urandom, $urandom};
      #2;
      exp_ready = m_resp ? 3'(3'b001 << m_port) : 3'b000;
      chk("rnd_rw_valid", 64'(rw_valid), 64'(m_busy));
      chk("rnd_rw_id", 64'(rw_id_o), m_busy ? 64'(m_port) : 64'd0);
      chk("rnd_rw_req", 64'(rw_req), m_busy ? 64'(m_we) : 64'd0);
      chk("rnd_rw_addr", 64'(rw_addr), m_busy ? 64'(m_addr) : 64'd0);
      chk("rnd_data_write", data_write, m_busy ? m_wdata : 64'd0);
      chk("rnd_w_mask", 64'(w_mask), m_busy ? 64'(m_mask) : 64'd0);
      chk("rnd_rw_size", 64'(rw_size), m_busy ? 64'(m_size) : 64'd0);
      chk("rnd_req_ready", 64'(req_ready), 64'(exp_ready));
      chk("rnd_resp_data", resp_data, m_resp ? m_rdata : 64'd0);
      chk("rnd_resp_err", 64'(resp_err), 64'(m_resp && m_rerr));
      chk("rnd_id_err", 64'(id_err), 64'(m_iderr));
      chk("rnd_stall", 64'(stallreq), 64'(|(req_valid & ~exp_ready)));
      // Advance the model across this clock edge.
      if (m_resp) begin
        m_resp = 0;
      end else if (m_busy) begin
        if (rw_ready && (rw_id == IW'(m_port))) begin
          m_busy = 0; m_resp = 1; m_rdata = data_read; m_rerr = 0;
        end else begin
          if (rw_ready) m_iderr = 1;
          if (cyc - m_issue == int'(TO)) begin
            m_busy = 0; m_resp = 1; m_rdata = '0; m_rerr = 1;
          end
        end
      end else if (req_valid != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          int p;
          p = (m_last + k) % 3;
          if (!m_busy && req_valid[p]) begin
            m_busy  = 1;
            m_port  = p;
            m_last  = p;
            m_issue = cyc + 1;
            m_we    = req_we[p];
            m_addr  = req_addr[p*AW +: AW];
            m_wdata = req_wdata[p*DW +: DW];
            m_mask  = req_mask[p*MW +: MW];
            m_size  = req_size[p*2 +: 2];
          end
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
